mem_stage: RTL and testbench

- Memory-access stage of the 5-stage MIPS pipeline, directly downstream of EX.
- Registers the EX→MEM bus and the HI/LO write bundle.
- Takes synchronous data-SRAM read data and extracts/extends load results (lw/lb/lbu/lh/lhu).
- Holds load data stable across pipeline stalls.
- Produces the MEM→WB bus and the MEM→ID forwarding bus.

---
 rtl/mem_stage_pkg.sv | 51 +++++
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage_load_extend.sv | 42 ++++
 rtl/mem_stage.sv | 82 ++++++++
 tb/tb_mem_stage.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// ------------------------------------------------------------------
// mem_stage_pkg : shared widths, stall encoding and load-type codes
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int STALL_W      = 6;
  localparam int HILO_W       = 66;
  localparam int MEM_TO_ID_WD = 38;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'b000,
    LOAD_LW   = 3'b001,
    LOAD_LB   = 3'b010,
    LOAD_LBU  = 3'b011,
    LOAD_LH   = 3'b100,
    LOAD_LHU  = 3'b101
  } load_type_e;

  typedef struct packed {
    logic [2:0]  load_type;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_wb_t;

  function automatic logic is_load(input logic [2:0] lt);
    return (lt >= LOAD_LW) && (lt <= LOAD_LHU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ------------------------------------------------------------------
// mem_stage_if : EX-side inputs and WB/ID-side outputs of the MEM stage
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface mem_stage_if;

  logic [mem_stage_pkg::STALL_W-1:0]      stall;
  logic [mem_stage_pkg::EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [mem_stage_pkg::HILO_W-1:0]       ex_hilo;
  logic [31:0]                            data_sram_rdata;
  logic [mem_stage_pkg::MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [mem_stage_pkg::MEM_TO_ID_WD-1:0] mem_to_id_bus;
  logic [mem_stage_pkg::HILO_W-1:0]       mem_hilo;

  modport master (
    output stall, ex_to_mem_bus, ex_hilo, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_id_bus, mem_hilo
  );

  modport slave (
    input  stall, ex_to_mem_bus, ex_hilo, data_sram_rdata,
    output mem_to_wb_bus, mem_to_id_bus, mem_hilo
  );

endinterface

`default_nettype wire

// File: rtl/mem_stage_load_extend.sv
// ------------------------------------------------------------------
// mem_stage_load_extend : byte/half lane select and sign/zero extension
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (addr)
      2'b01:   byte_v = rdata[15:8];
      2'b10:   byte_v = rdata[23:16];
      2'b11:   byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    // Halfword and word accesses ignore the low address bits: no alignment trap.
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];

    result = rdata;
    case (load_type)
      LOAD_LB:  result = {{24{byte_v[7]}}, byte_v};
      LOAD_LBU: result = {24'h0, byte_v};
      LOAD_LH:  result = {{16{half_v[15]}}, half_v};
      LOAD_LHU: result = {16'h0, half_v};
      default:  result = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ------------------------------------------------------------------
// mem_stage : MIPS MEM stage - EX/MEM register, load extraction, stall hold
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  ex_to_mem_t          ex_in;
  ex_to_mem_t          bus_r;
  logic [HILO_W-1:0]   hilo_r;
  logic                hold_valid;
  logic [31:0]         hold_data;
  logic [31:0]         rdata_eff;
  logic [31:0]         load_val;
  mem_to_wb_t          wb;
  logic                ex_stop;
  logic                mem_stop;

  assign ex_in    = bus.ex_to_mem_bus;
  assign ex_stop  = (bus.stall[3] == STOP);
  assign mem_stop = (bus.stall[4] == STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_r  <= '0;
      hilo_r <= '0;
    end else if (ex_stop && !mem_stop) begin
      bus_r  <= '0;
      hilo_r <= '0;
    end else if (!ex_stop) begin
      bus_r  <= ex_in;
      hilo_r <= bus.ex_hilo;
    end
  end

  // The SRAM output may drift while MEM is frozen; the first stalled sample wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
    end else if (mem_stop && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_data  <= bus.data_sram_rdata;
    end else if (!mem_stop) begin
      hold_valid <= 1'b0;
    end
  end

  assign rdata_eff = hold_valid ? hold_data : bus.data_sram_rdata;

  mem_stage_load_extend u_load_extend (
    .load_type (bus_r.load_type),
    .addr      (bus_r.ex_result[1:0]),
    .rdata     (rdata_eff),
    .result    (load_val)
  );

  always_comb begin
    wb.pc       = bus_r.pc;
    wb.rf_we    = bus_r.rf_we;
    wb.rf_waddr = bus_r.rf_waddr;
    wb.rf_wdata = (bus_r.sel_rf_res || is_load(bus_r.load_type)) ? load_val
                                                                  : bus_r.ex_result;
  end

  assign bus.mem_to_wb_bus = wb;
  assign bus.mem_to_id_bus = {wb.rf_we, wb.rf_waddr, wb.rf_wdata};
  assign bus.mem_hilo      = hilo_r;

  logic unused_ok;
  assign unused_ok = ^{bus_r.data_ram_en, bus_r.data_ram_wen,
                       bus.stall[5], bus.stall[2:0]};

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ------------------------------------------------------------------
// tb_mem_stage : directed self-checking bench for mem_stage
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_stage_if bus_if ();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  localparam logic [2:0] LT_NONE = 3'b000;
  localparam logic [2:0] LT_LW   = 3'b001;
  localparam logic [2:0] LT_LB   = 3'b010;
  localparam logic [2:0] LT_LBU  = 3'b011;
  localparam logic [2:0] LT_LH   = 3'b100;
  localparam logic [2:0] LT_LHU  = 3'b101;

  function automatic logic [78:0] make_ex(input logic [2:0] lt, input logic [31:0] pc,
                                          input logic sel, input logic we,
                                          input logic [4:0] wa, input logic [31:0] res);
    return {lt, pc, (lt != 3'b000), 4'h0, sel, we, wa, res};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.stall           = 6'h3f;
    bus_if.ex_to_mem_bus   = make_ex(LT_LW, 32'h1234, 1'b1, 1'b1, 5'd3, 32'h8);
    bus_if.ex_hilo         = {2'b11, 32'h5, 32'h6};
    bus_if.data_sram_rdata = 32'hCAFEF00D;
    tick();
    tick();
    checks++;
    if (bus_if.mem_to_wb_bus !== 70'h0) begin
      errors++;
      $display("FAIL reset_wb got %h exp 0", bus_if.mem_to_wb_bus);
    end
    checks++;
    if (bus_if.mem_to_id_bus !== 38'h0) begin
      errors++;
      $display("FAIL reset_id got %h exp 0", bus_if.mem_to_id_bus);
    end
    checks++;
    if (bus_if.mem_hilo !== 66'h0) begin
      errors++;
      $display("FAIL reset_hilo got %h exp 0", bus_if.mem_hilo);
    end
    rst = 1'b0;
    bus_if.stall = 6'h00;
  endtask

  task automatic test_lw();
    bus_if.ex_to_mem_bus = make_ex(LT_LW, 32'hBFC00010, 1'b1, 1'b1, 5'd8, 32'h1000);
    tick();
    bus_if.data_sram_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus_if.mem_to_wb_bus !== {32'hBFC00010, 1'b1, 5'd8, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL lw_wb got %h exp %h", bus_if.mem_to_wb_bus,
               {32'hBFC00010, 1'b1, 5'd8, 32'hDEADBEEF});
    end
    checks++;
    if (bus_if.mem_to_id_bus !== {1'b1, 5'd8, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL lw_id got %h exp %h", bus_if.mem_to_id_bus, {1'b1, 5'd8, 32'hDEADBEEF});
    end
  endtask

  logic [2:0]  ext_lt  [12] = '{LT_LB, LT_LBU, LT_LH, LT_LHU, LT_LB, LT_LB,
                                LT_LH, LT_LBU, LT_LB, LT_LW, LT_LHU, LT_NONE};
  logic [1:0]  ext_ad  [12] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0,
                                2'd0, 2'd2, 2'd2, 2'd3, 2'd1, 2'd3};
  logic [31:0] ext_exp [12] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                                32'h0000007F, 32'h00000001, 32'h00007F01, 32'h000000FF,
                                32'hFFFFFFFF, 32'h80FF7F01, 32'h00007F01, 32'h00001003};

  task automatic test_back_to_back_extract();
    for (int i = 0; i < 12; i++) begin
      bus_if.ex_to_mem_bus = make_ex(ext_lt[i], 32'h400 + 32'(i * 4), 1'b0, 1'b1,
                                     5'(i + 1), {30'h400, ext_ad[i]});
      tick();
      bus_if.data_sram_rdata = 32'h80FF7F01;
      #1;
      checks++;
      if (bus_if.mem_to_wb_bus[31:0] !== ext_exp[i] ||
          bus_if.mem_to_wb_bus[36:32] !== 5'(i + 1)) begin
        errors++;
        $display("FAIL extract[%0d] got %h exp data %h waddr %0d", i,
                 bus_if.mem_to_wb_bus, ext_exp[i], i + 1);
      end
    end
  endtask

  task automatic test_stall_hold();
    bus_if.ex_to_mem_bus = make_ex(LT_LW, 32'h2000, 1'b1, 1'b1, 5'd9, 32'h40);
    tick();
    bus_if.data_sram_rdata = 32'h12345678;
    bus_if.stall = 6'b011111;
    #1;
    checks++;
    if (bus_if.mem_to_wb_bus[31:0] !== 32'h12345678) begin
      errors++;
      $display("FAIL hold_first got %h exp 12345678", bus_if.mem_to_wb_bus[31:0]);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      bus_if.data_sram_rdata = 32'hAAAAAAAA;
      #1;
      checks++;
      if (bus_if.mem_to_wb_bus[31:0] !== 32'h12345678 ||
          bus_if.mem_to_wb_bus[69:38] !== 32'h2000) begin
        errors++;
        $display("FAIL hold_cycle[%0d] got %h exp data 12345678 pc 2000", c,
                 bus_if.mem_to_wb_bus);
      end
    end
    bus_if.stall = 6'b000000;
    tick();
    #1;
    checks++;
    if (bus_if.mem_to_wb_bus[31:0] !== 32'hAAAAAAAA) begin
      errors++;
      $display("FAIL hold_release got %h exp aaaaaaaa", bus_if.mem_to_wb_bus[31:0]);
    end
  endtask

  task automatic test_bubble();
    bus_if.ex_to_mem_bus = make_ex(LT_NONE, 32'h100, 1'b0, 1'b1, 5'd5, 32'h55);
    bus_if.ex_hilo = {2'b11, 32'h7, 32'h9};
    tick();
    #1;
    checks++;
    if (bus_if.mem_to_id_bus !== {1'b1, 5'd5, 32'h55}) begin
      errors++;
      $display("FAIL addu_id got %h exp %h", bus_if.mem_to_id_bus, {1'b1, 5'd5, 32'h55});
    end
    bus_if.stall = 6'b001111;
    tick();
    #1;
    checks++;
    if (bus_if.mem_to_wb_bus !== 70'h0) begin
      errors++;
      $display("FAIL bubble_wb got %h exp 0", bus_if.mem_to_wb_bus);
    end
    checks++;
    if (bus_if.mem_hilo !== 66'h0) begin
      errors++;
      $display("FAIL bubble_hilo got %h exp 0", bus_if.mem_hilo);
    end
    bus_if.stall = 6'b000000;
  endtask

  task automatic test_hilo();
    bus_if.ex_to_mem_bus = 79'h0;
    bus_if.ex_hilo = {1'b1, 1'b1, 32'h1, 32'h2};
    tick();
    #1;
    checks++;
    if (bus_if.mem_hilo !== {1'b1, 1'b1, 32'h1, 32'h2}) begin
      errors++;
      $display("FAIL hilo_pass got %h exp %h", bus_if.mem_hilo, {1'b1, 1'b1, 32'h1, 32'h2});
    end
    bus_if.stall = 6'b011111;
    bus_if.ex_hilo = {1'b0, 1'b1, 32'hFFFF, 32'hEEEE};
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      checks++;
      if (bus_if.mem_hilo !== {1'b1, 1'b1, 32'h1, 32'h2}) begin
        errors++;
        $display("FAIL hilo_held[%0d] got %h exp %h", c, bus_if.mem_hilo,
                 {1'b1, 1'b1, 32'h1, 32'h2});
      end
    end
    bus_if.stall = 6'b000000;
    bus_if.ex_hilo = 66'h0;
  endtask

  task automatic test_reset_mid_hold();
    bus_if.ex_to_mem_bus = make_ex(LT_LW, 32'h3000, 1'b1, 1'b1, 5'd10, 32'h80);
    bus_if.ex_hilo = {2'b10, 32'h3, 32'h4};
    tick();
    bus_if.data_sram_rdata = 32'h11111111;
    bus_if.stall = 6'b011111;
    tick();
    bus_if.data_sram_rdata = 32'h22222222;
    #1;
    checks++;
    if (bus_if.mem_to_wb_bus[31:0] !== 32'h11111111) begin
      errors++;
      $display("FAIL prerst_hold got %h exp 11111111", bus_if.mem_to_wb_bus[31:0]);
    end
    rst = 1'b1;
    bus_if.stall = 6'b000000;
    tick();
    #1;
    checks++;
    if (bus_if.mem_to_wb_bus !== 70'h0 || bus_if.mem_to_id_bus !== 38'h0 ||
        bus_if.mem_hilo !== 66'h0) begin
      errors++;
      $display("FAIL midrst_outputs got wb %h id %h hilo %h exp all 0",
               bus_if.mem_to_wb_bus, bus_if.mem_to_id_bus, bus_if.mem_hilo);
    end
    rst = 1'b0;
    tick();
    bus_if.data_sram_rdata = 32'h33333333;
    #1;
    checks++;
    if (bus_if.mem_to_wb_bus[31:0] !== 32'h33333333) begin
      errors++;
      $display("FAIL postrst_live got %h exp 33333333", bus_if.mem_to_wb_bus[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back_extract();
    test_stall_hold();
    test_bubble();
    test_hilo();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
